// File: rtl/sram_rd_streamer.sv
// sram_rd_streamer: burst reader for a 1-cycle-latency SRAM with a credit-gated 2-entry output FIFO.
// Optional out_last port enabled by defining SRAM_RD_STREAMER_LAST_EN.
module sram_rd_streamer #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 128,
  parameter int LEN_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              sram_cen,
  output logic              sram_wen,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_d,
  input  logic [DATA_W-1:0] sram_q,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
`ifdef SRAM_RD_STREAMER_LAST_EN
  ,
  output logic              out_last
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [ADDR_W-1:0] ptr, last_a;
  logic [LEN_W-1:0] remaining, beats_left;
  logic inflight, inflight_last;
  logic [DATA_W-1:0] mem_d [2];
  logic [1:0] mem_l;
  logic rp, wp;
  logic [1:0] count;
  logic pop, issue;
  assign out_valid = count != 2'd0;
  assign pop = out_valid && out_ready;
  // a word in flight already owns a FIFO slot; a pop this cycle frees one
  assign issue = !reset && state == RUN && remaining != '0 &&
                 ({1'b0, count} + 3'(inflight)) < (3'd2 + 3'(pop));
  assign sram_cen = !issue;
  assign sram_wen = 1'b1;
  assign sram_d = '0;
  assign sram_a = issue ? ptr : last_a;
  assign out_data = mem_d[rp];
  assign busy = state != IDLE;
  assign done = state == DONE;
`ifdef SRAM_RD_STREAMER_LAST_EN
  assign out_last = out_valid && mem_l[rp];
`else
  logic unused_last;
  assign unused_last = ^{mem_l, inflight_last};
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
      last_a <= '0;
      remaining <= '0;
      beats_left <= '0;
      inflight <= 1'b0;
      inflight_last <= 1'b0;
      mem_d[0] <= '0;
      mem_d[1] <= '0;
      mem_l <= '0;
      rp <= 1'b0;
      wp <= 1'b0;
      count <= '0;
    end else begin
      inflight <= issue;
      inflight_last <= issue && remaining == LEN_W'(1);
      count <= count + 2'(inflight) - 2'(pop);
      if (issue) begin
        ptr <= ptr + 1'b1;
        last_a <= ptr;
        remaining <= remaining - 1'b1;
      end
      if (inflight) begin
        mem_d[wp] <= sram_q;
        mem_l[wp] <= inflight_last;
        wp <= ~wp;
      end
      if (pop) begin
        rp <= ~rp;
        beats_left <= beats_left - 1'b1;
      end
      case (state)
        IDLE:
          if (start) begin
            state <= len != '0 ? RUN : DONE;
            ptr <= base_addr;
            remaining <= len;
            beats_left <= len;
          end
        RUN: if (pop && beats_left == LEN_W'(1)) state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_rd_streamer.sv
// tb_sram_rd_streamer: directed bench for sram_rd_streamer with a registered-read SRAM model.
module tb_sram_rd_streamer;
  localparam int AW = 4, DW = 128, LW = 5;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, out_ready = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] len = '0;
  logic busy, done, sram_cen, sram_wen, out_valid;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_d, out_data;
  logic [DW-1:0] sram_q = '0;
  logic [DW-1:0] mem [16];
`ifdef SRAM_RD_STREAMER_LAST_EN
  logic out_last;
`endif
  int total = 0, bad = 0;

  sram_rd_streamer dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .sram_cen(sram_cen), .sram_wen(sram_wen),
    .sram_a(sram_a), .sram_d(sram_d), .sram_q(sram_q),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
`ifdef SRAM_RD_STREAMER_LAST_EN
    , .out_last(out_last)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (!sram_cen && sram_wen) sram_q <= mem[sram_a];

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, DW'(busy), 0);
    check({tag, "_done"}, DW'(done), 0);
    check({tag, "_cen"}, DW'(sram_cen), 1);
    check({tag, "_wen"}, DW'(sram_wen), 1);
    check({tag, "_a"}, DW'(sram_a), 0);
    check({tag, "_d"}, sram_d, 0);
    check({tag, "_valid"}, DW'(out_valid), 0);
    check({tag, "_data"}, out_data, 0);
  endtask

  task automatic run_burst(input logic [AW-1:0] b, input logic [LW-1:0] l, input bit rnd, input bit poke);
    int beats = 0, issued = 0, done_k = -1, viol = 0, cnt = 0, infl = 0, p;
    logic [AW-1:0] ea;
    @(negedge clk);
    start = 1'b1; base_addr = b; len = l; out_ready = 1'b1;
    #1;
    check("idle_busy", DW'(busy), 0);
    for (int k = 1; k < 300 && done_k < 0; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (poke && k == 2) begin
        start = 1'b1; base_addr = 4'd9; len = 5'd3;
      end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      p = (out_valid && out_ready) ? 1 : 0;
      if (!sram_cen) begin
        if (cnt + infl - p >= 2) viol++;
        ea = b + AW'(issued);
        check("addr", DW'(sram_a), DW'(ea));
        issued++;
      end
      if (p == 1) begin
        ea = b + AW'(beats);
        check("data", out_data, DW'(ea));
`ifdef SRAM_RD_STREAMER_LAST_EN
        check("last", DW'(out_last), DW'(beats == int'(l) - 1));
`endif
        beats++;
      end
      if (!rnd) check("busy", DW'(busy), 1);
      if (done) done_k = k;
      cnt = cnt + infl - p;
      infl = sram_cen ? 0 : 1;
    end
    check("beats", DW'(beats), DW'(l));
    check("issued", DW'(issued), DW'(l));
    check("credit", DW'(viol), 0);
    if (!rnd) check("done_cyc", DW'(done_k), DW'(l == 0 ? 1 : int'(l) + 3));
    else check("done_seen", DW'(done_k > 0), 1);
    @(negedge clk);
    #1;
    check("post_busy", DW'(busy), 0);
    check("post_done", DW'(done), 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = DW'(i);
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("rst");
    reset = 1'b0;
    run_burst(4'd2, 5'd4, 1'b0, 1'b0);
    run_burst(4'd14, 5'd4, 1'b0, 1'b0);
    run_burst(4'd0, 5'd16, 1'b1, 1'b0);
    run_burst(4'd3, 5'd0, 1'b0, 1'b0);
    run_burst(4'd7, 5'd5, 1'b0, 1'b1);
    run_burst(4'd11, 5'd16, 1'b0, 1'b0);
    // abort a len=8 burst after three beats
    @(negedge clk);
    start = 1'b1; base_addr = 4'd0; len = 5'd8; out_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (k == 5) begin
        check("abort_valid", DW'(out_valid), 1);
        check("abort_data", out_data, 2);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_outputs("abort");
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      check("abort_nodone", DW'(done), 0);
      check("abort_novalid", DW'(out_valid), 0);
    end
    run_burst(4'd5, 5'd2, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
